// File: rtl/icache_param.sv
// icache_param: parametrised set-associative read-only instruction cache with word-serial refill.
// Ports: clk, resetn (async active-low); cpu_req/cpu_addr/cpu_inv in, cpu_rdata/cpu_stall out;
//        mem_rd_req/mem_rd_addr out, mem_rd_gnt/mem_rvalid/mem_rdata in.
// Build option: define ICACHE_PLRU_EN for tree pseudo-LRU replacement, otherwise round-robin.
module icache_param #(
    parameter int WAYS       = 4,
    parameter int SETS       = 128,
    parameter int LINE_WORDS = 8
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        cpu_req,
    input  logic [31:0] cpu_addr,
    input  logic        cpu_inv,
    output logic [31:0] cpu_rdata,
    output logic        cpu_stall,
    output logic        mem_rd_req,
    output logic [31:0] mem_rd_addr,
    input  logic        mem_rd_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);
    localparam int WAY_W  = $clog2(WAYS);
    localparam int WORD_W = $clog2(LINE_WORDS);
    localparam int OFF_W  = WORD_W + 2;
    localparam int IDX_W  = $clog2(SETS);
    localparam int TAG_W  = 32 - IDX_W - OFF_W;
    localparam logic [31:0] LINE_MASK = ~((32'd1 << OFF_W) - 32'd1);

    typedef enum logic [2:0] {INIT, LOOKUP, MISS, REFILL, DONE} state_t;
    state_t state, state_n;

    logic [31:0]      data_mem [WAYS][SETS*LINE_WORDS];
    logic [TAG_W-1:0] tag_mem  [WAYS][SETS];
    logic [WAYS-1:0]  valid    [SETS];
`ifdef ICACHE_PLRU_EN
    // Tree node n lives at bit n (children 2n+1, 2n+2); the top bit is padding.
    // Level l of the tree steers address bit l of the way number.
    logic [WAYS-1:0]  repl     [SETS];
`else
    logic [WAY_W-1:0] repl     [SETS];
`endif

    logic [TAG_W-1:0]  tag;
    logic [IDX_W-1:0]  idx, fill_idx, set_cnt;
    logic [WORD_W-1:0] word, beat_cnt;
    logic [WAY_W-1:0]  hit_way, victim, fill_way, policy_way;
    logic              hit, inv_pend, inv_now;

    assign tag      = cpu_addr[31 -: TAG_W];
    assign idx      = cpu_addr[OFF_W +: IDX_W];
    assign word     = cpu_addr[2 +: WORD_W];
    assign fill_idx = mem_rd_addr[OFF_W +: IDX_W];
    // A pending invalidate is honoured on the first LOOKUP cycle after a refill.
    assign inv_now  = cpu_inv || inv_pend;

`ifdef ICACHE_PLRU_EN
    function automatic logic [WAY_W-1:0] plru_victim(input logic [WAYS-1:0] t);
        logic [WAY_W-1:0] n;
        n = '0;
        plru_victim = '0;
        for (int l = 0; l < WAY_W; l++) begin
            plru_victim[l] = t[n];
            n = (n << 1) + WAY_W'(1) + WAY_W'(t[n]);
        end
    endfunction

    function automatic logic [WAYS-1:0] plru_touch(input logic [WAYS-1:0] t, input logic [WAY_W-1:0] w);
        logic [WAY_W-1:0] n;
        n = '0;
        plru_touch = t;
        for (int l = 0; l < WAY_W; l++) begin
            plru_touch[n] = ~w[l];
            n = (n << 1) + WAY_W'(1) + WAY_W'(w[l]);
        end
    endfunction

    assign policy_way = plru_victim(repl[idx]);
`else
    assign policy_way = repl[idx];
`endif

    // Hit search plus victim choice: the downward scan leaves the lowest invalid way.
    always_comb begin
        hit = 1'b0;
        hit_way = '0;
        victim = policy_way;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (valid[idx][WAY_W'(w)] && tag_mem[WAY_W'(w)][idx] == tag) begin
                hit = 1'b1;
                hit_way = WAY_W'(w);
            end
            if (!valid[idx][WAY_W'(w)])
                victim = WAY_W'(w);
        end
    end

    always_comb begin
        state_n = state;
        cpu_stall = 1'b1;
        cpu_rdata = '0;
        case (state)
            INIT:    state_n = (!cpu_inv && &set_cnt) ? LOOKUP : INIT;
            LOOKUP: begin
                cpu_stall = inv_now || (cpu_req && !hit);
                cpu_rdata = (!inv_now && cpu_req && hit) ? data_mem[hit_way][{idx, word}] : '0;
                state_n = inv_now ? INIT : (cpu_req && !hit) ? MISS : LOOKUP;
            end
            MISS:    state_n = mem_rd_gnt ? REFILL : MISS;
            REFILL:  state_n = (mem_rvalid && &beat_cnt) ? DONE : REFILL;
            DONE:    state_n = LOOKUP;
            default: state_n = INIT;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            state <= INIT;
        else
            state <= state_n;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            set_cnt     <= '0;
            beat_cnt    <= '0;
            inv_pend    <= 1'b0;
            mem_rd_req  <= 1'b0;
            mem_rd_addr <= '0;
            fill_way    <= '0;
        end else begin
            set_cnt    <= (state == INIT && !cpu_inv) ? set_cnt + IDX_W'(1) : '0;
            beat_cnt   <= (state != REFILL) ? '0 : beat_cnt + WORD_W'(mem_rvalid);
            inv_pend   <= state_n != INIT && (inv_pend || cpu_inv);
            mem_rd_req <= state_n == MISS;
            if (state == LOOKUP && state_n == MISS) begin
                mem_rd_addr <= cpu_addr & LINE_MASK;
                fill_way    <= victim;
            end
        end
    end

    // Arrays carry no reset: INIT sweeps the valid and replacement state instead.
    always_ff @(posedge clk) begin
        if (state == INIT) begin
            valid[set_cnt] <= '0;
            repl[set_cnt]  <= '0;
        end
        if (state == REFILL && mem_rvalid) begin
            data_mem[fill_way][{fill_idx, beat_cnt}] <= mem_rdata;
            if (&beat_cnt) begin
                tag_mem[fill_way][fill_idx] <= mem_rd_addr[31 -: TAG_W];
                valid[fill_idx][fill_way]   <= 1'b1;
`ifdef ICACHE_PLRU_EN
                repl[fill_idx] <= plru_touch(repl[fill_idx], fill_way);
`else
                repl[fill_idx] <= repl[fill_idx] + WAY_W'(1);
`endif
            end
        end
`ifdef ICACHE_PLRU_EN
        if (state == LOOKUP && cpu_req && hit && !inv_now)
            repl[idx] <= plru_touch(repl[idx], hit_way);
`endif
    end
endmodule

// File: tb/tb_icache_param.sv
// tb_icache_param: directed plus randomized bench for icache_param (default round-robin build).
// Ports driven: all DUT inputs; the bench plays the CPU and the memory bridge and keeps a
// line-level model of cache contents to predict hits, misses and returned words.
module tb_icache_param;
    localparam int WAYS = 4;
    localparam int SETS = 128;
    localparam int LW   = 8;

    logic        clk = 1'b0;
    logic        resetn, cpu_req, cpu_inv, mem_rd_gnt, mem_rvalid;
    logic [31:0] cpu_addr, mem_rdata;
    logic [31:0] cpu_rdata, mem_rd_addr;
    logic        cpu_stall, mem_rd_req;

    int checks = 0;
    int errors = 0;

    bit          mv    [SETS][WAYS];
    logic [31:0] mline [SETS][WAYS];
    logic [31:0] md    [SETS][WAYS][LW];
    int          mrr   [SETS];
    logic [31:0] beats [LW];

    icache_param #(.WAYS(WAYS), .SETS(SETS), .LINE_WORDS(LW)) dut (
        .clk(clk), .resetn(resetn), .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_inv(cpu_inv),
        .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall), .mem_rd_req(mem_rd_req),
        .mem_rd_addr(mem_rd_addr), .mem_rd_gnt(mem_rd_gnt), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", name, obs, exp);
        end
    endtask

    task automatic init_len(input string name, input int lo, input int hi);
        int n = 0;
        while (cpu_stall === 1'b1 && n < 4000) begin
            n++;
            @(negedge clk);
            #1;
        end
        checks++;
        assert (n >= lo && n <= hi) else begin
            errors++;
            $error("FAIL %s: got %0d stall cycles expected %0d..%0d", name, n, lo, hi);
        end
    endtask

    task automatic mclear();
        for (int s = 0; s < SETS; s++) begin
            mrr[s] = 0;
            for (int w = 0; w < WAYS; w++) mv[s][w] = 0;
        end
    endtask

    task automatic rnd_beats();
        for (int b = 0; b < LW; b++) beats[b] = $urandom;
    endtask

    task automatic async_rst();
        #2 resetn = 1'b0;
        #1;
        chk("rst_req", mem_rd_req, 0);
        chk("rst_stall", cpu_stall, 1);
        chk("rst_rdata", cpu_rdata, 0);
        mem_rvalid = 0;
        mem_rd_gnt = 0;
        cpu_req = 0;
    endtask

    // One CPU fetch. d = extra cycles before grant, inv_b = beat carrying cpu_inv (-1 none),
    // extra = drive a stray beat in the bubble cycle, abort_b = beat at which resetn drops
    // (-2 drops it while the request is pending, -1 never).
    task automatic fetch(input logic [31:0] a, input int d, input int inv_b, input bit extra, input int abort_b);
        int s, w, way;
        logic [31:0] line;
        bit hit;
        s = int'((a >> 5) % SETS);
        w = int'((a >> 2) % LW);
        line = a - (a % (4 * LW));
        hit = 0;
        way = 0;
        for (int i = 0; i < WAYS; i++)
            if (mv[s][i] && mline[s][i] == line) begin
                hit = 1;
                way = i;
            end
        @(negedge clk);
        cpu_req = 1;
        cpu_addr = a;
        #1;
        if (hit) begin
            chk("hit_stall", cpu_stall, 0);
            chk("hit_data", cpu_rdata, md[s][way][w]);
            chk("hit_noreq", mem_rd_req, 0);
            cpu_req = 0;
            return;
        end
        chk("miss_stall", cpu_stall, 1);
        way = -1;
        for (int i = WAYS - 1; i >= 0; i--) if (!mv[s][i]) way = i;
        if (way < 0) way = mrr[s];
        for (int k = 0; k <= d; k++) begin
            @(negedge clk);
            mem_rd_gnt = (k == d);
            #1;
            chk("req_hold", mem_rd_req, 1);
            chk("req_addr", mem_rd_addr, line);
            chk("miss_busy", cpu_stall, 1);
            if (abort_b == -2) begin
                async_rst();
                return;
            end
        end
        @(negedge clk);
        mem_rd_gnt = 0;
        for (int b = 0; b < LW; b++) begin
            if (b > 0) @(negedge clk);
            if (b == abort_b) begin
                async_rst();
                return;
            end
            mem_rvalid = 1;
            mem_rdata = beats[b];
            cpu_inv = (b == inv_b);
            #1;
            if (b == 0) chk("req_drop", mem_rd_req, 0);
            chk("refill_stall", cpu_stall, 1);
        end
        @(negedge clk);
        mem_rvalid = extra;
        mem_rdata = 32'hDEAD_BEEF;
        cpu_inv = 0;
        if (inv_b >= 0) cpu_req = 0;
        #1;
        chk("done_stall", cpu_stall, 1);
        if (inv_b >= 0) begin
            init_len("inv_refill_init", SETS + 1, SETS + 2);
            mclear();
            return;
        end
        mv[s][way] = 1;
        mline[s][way] = line;
        for (int b = 0; b < LW; b++) md[s][way][b] = beats[b];
        mrr[s] = (mrr[s] + 1) % WAYS;
        @(negedge clk);
        mem_rvalid = 0;
        mem_rdata = 0;
        #1;
        chk("post_done_stall", cpu_stall, 0);
        chk("post_done_data", cpu_rdata, beats[w]);
        cpu_req = 0;
    endtask

    task automatic fetch_r(input logic [31:0] a);
        rnd_beats();
        fetch(a, int'($urandom_range(0, 3)), -1, 1'($urandom_range(0, 1)), -1);
    endtask

    initial begin
        logic [31:0] a;
        resetn = 0;
        cpu_req = 0;
        cpu_addr = 0;
        cpu_inv = 0;
        mem_rd_gnt = 0;
        mem_rvalid = 0;
        mem_rdata = 0;
        mclear();
        repeat (3) @(negedge clk);
        #1;
        chk("reset_stall", cpu_stall, 1);
        chk("reset_rdata", cpu_rdata, 0);
        chk("reset_req", mem_rd_req, 0);
        chk("reset_addr", mem_rd_addr, 0);
        @(negedge clk);
        resetn = 1;
        #1;
        init_len("init_len", SETS, SETS);
        chk("idle_rdata", cpu_rdata, 0);

        for (int b = 0; b < LW; b++) beats[b] = 32'hA0 + b;
        fetch(32'h0000_1000, 2, -1, 0, -1);
        fetch(32'h0000_1014, 0, -1, 0, -1);
        fetch(32'h0000_101C, 0, -1, 0, -1);

        // stray beat while looking up a resident line
        @(negedge clk);
        cpu_req = 1;
        cpu_addr = 32'h0000_1014;
        mem_rvalid = 1;
        mem_rdata = 32'h5555_5555;
        #1;
        chk("stray_hit", cpu_rdata, 32'hA5);
        @(negedge clk);
        mem_rvalid = 0;
        #1;
        chk("stray_after", cpu_rdata, 32'hA5);
        cpu_req = 0;

        // fill set 0 with four tags, then a fifth evicts the first-filled line
        fetch_r(32'h0000_0000);
        fetch_r(32'h0000_2000);
        fetch_r(32'h0000_3000);
        fetch_r(32'h0000_4008);
        fetch(32'h0000_2004, 0, -1, 0, -1);
        fetch_r(32'h0000_1014);
        fetch(32'h0000_3010, 0, -1, 0, -1);

        // ninth beat during the bubble cycle
        rnd_beats();
        fetch(32'h0000_5000, 1, -1, 1, -1);
        fetch(32'h0000_501C, 0, -1, 0, -1);

        // invalidate from LOOKUP
        @(negedge clk);
        cpu_inv = 1;
        #1;
        chk("inv_stall", cpu_stall, 1);
        @(negedge clk);
        cpu_inv = 0;
        #1;
        init_len("inv_init_len", SETS, SETS);
        mclear();
        fetch_r(32'h0000_5004);

        // invalidate at the third refill beat, then the same line misses again
        rnd_beats();
        fetch(32'h0000_1000, 0, 2, 0, -1);
        fetch_r(32'h0000_1000);
        fetch(32'h0000_1004, 0, -1, 0, -1);

        for (int i = 0; i < 80; i++) begin
            a = (32'($urandom_range(0, 5)) << 12) | (32'($urandom_range(0, 3)) << 5) |
                (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
            fetch_r(a);
            if ($urandom_range(0, 3) == 0) begin
                @(negedge clk);
                cpu_req = 0;
                mem_rvalid = 1'($urandom_range(0, 1));
                mem_rdata = $urandom;
                #1;
                chk("idle_stall", cpu_stall, 0);
                chk("idle_zero", cpu_rdata, 0);
                @(negedge clk);
                mem_rvalid = 0;
            end
        end

        // asynchronous reset while the request is pending, then mid-refill
        fetch(32'h0000_1000, 0, -1, 0, -1);
        rnd_beats();
        fetch(32'h0004_0000, 1, -1, 0, -2);
        repeat (2) @(negedge clk);
        resetn = 1;
        #1;
        init_len("init_after_rst_miss", SETS, SETS);
        mclear();
        fetch_r(32'h0000_1000);
        fetch(32'h0000_1000, 0, -1, 0, -1);
        rnd_beats();
        fetch(32'h0004_0000, 0, -1, 0, 3);
        repeat (2) @(negedge clk);
        resetn = 1;
        #1;
        init_len("init_after_rst_refill", SETS, SETS);
        mclear();
        fetch_r(32'h0000_1000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
